// File: rtl/lcd_responder.sv
// rtl/lcd_responder.sv - HD44780-style LCD bus responder (optional LCD_RESPONDER_INIT_CHECK_EN).
module lcd_responder #(
    parameter int BUSY_CYCLES  = 2000,
    parameter int CLEAR_CYCLES = 76500
) (
    input  logic       clk,
    input  logic       LCDonIn,
    input  logic       LCDenableOut,
    input  logic       LCDrsSelect,
    input  logic       LCDreadWriteSel,
    input  logic [7:0] LCDbusIn,
    output logic [7:0] LCDbusOut,
    output logic       LCDbusOe,
    output logic       busyFlag,
    output logic       displayOn,
    output logic       protocolErr,
    input  logic [6:0] dbgAddr,
    output logic [7:0] dbgData
);

    localparam int CLEAR_TOTAL = (CLEAR_CYCLES > 80) ? CLEAR_CYCLES : 80;
    localparam int MAX_CYCLES  = (CLEAR_TOTAL > BUSY_CYCLES) ? CLEAR_TOTAL : BUSY_CYCLES;
    localparam int CNT_W       = $clog2(MAX_CYCLES + 1);
    localparam logic [6:0] LAST_ADDR = 7'h4F;

    logic [7:0]       ddram [0:79];
    logic             e_q;
    logic [6:0]       ac;
    logic             id, d, c, b, dl, n, f;
    logic             bf, err;
    logic [CNT_W-1:0] busy_cnt;
    logic             fill_on;
    logic [6:0]       fill_addr;

    logic       strobe, wr_stb, rd_data_stb, wr_ok, rd_ok, is_fset, is_clear, init_ok;
    logic [6:0] ac_step;

    assign strobe      = e_q & ~LCDenableOut;
    assign wr_stb      = strobe & ~LCDreadWriteSel;
    assign rd_data_stb = strobe & LCDreadWriteSel & LCDrsSelect;
    assign is_fset     = ~LCDrsSelect & (LCDbusIn[7:5] == 3'b001);
    assign is_clear    = ~LCDrsSelect & (LCDbusIn == 8'h01);

`ifdef LCD_RESPONDER_INIT_CHECK_EN
    logic init_done;
    assign init_ok = init_done | is_fset;
`else
    assign init_ok = 1'b1;
`endif

    assign wr_ok   = wr_stb & ~bf & init_ok;
    assign rd_ok   = rd_data_stb & ~bf;
    assign ac_step = id ? ((ac == LAST_ADDR) ? 7'h00 : ac + 7'd1)
                        : ((ac == 7'h00) ? LAST_ADDR : ac - 7'd1);

    always_ff @(posedge clk or negedge LCDonIn) begin
        if (!LCDonIn) begin
            e_q       <= 1'b0;
            ac        <= 7'h00;
            id        <= 1'b1;
            {d, c, b} <= 3'b000;
            {dl, n, f} <= 3'b000;
            bf        <= 1'b0;
            busy_cnt  <= '0;
            err       <= 1'b0;
            fill_on   <= 1'b0;
            fill_addr <= 7'h00;
`ifdef LCD_RESPONDER_INIT_CHECK_EN
            init_done <= 1'b0;
`endif
        end else begin
            e_q <= LCDenableOut;
            if ((wr_stb & ~wr_ok) | (rd_data_stb & bf))
                err <= 1'b1;

            // Busy countdown: BF is high for exactly the loaded count + 1 cycles.
            if (wr_ok) begin
                bf       <= 1'b1;
                busy_cnt <= is_clear ? CNT_W'(CLEAR_TOTAL - 1) : CNT_W'(BUSY_CYCLES - 1);
            end else if (bf) begin
                if (busy_cnt == '0)
                    bf <= 1'b0;
                else
                    busy_cnt <= busy_cnt - 1'b1;
            end

            if (wr_ok & is_clear) begin
                fill_on   <= 1'b1;
                fill_addr <= 7'h00;
            end else if (fill_on) begin
                if (fill_addr == LAST_ADDR)
                    fill_on <= 1'b0;
                fill_addr <= fill_addr + 7'd1;
            end

            if (wr_ok & ~LCDrsSelect) begin
                casez (LCDbusIn)
                    8'b1???????: ac <= (LCDbusIn[6:0] > LAST_ADDR) ? 7'h00 : LCDbusIn[6:0];
                    8'b001?????: begin
                        {dl, n, f} <= LCDbusIn[4:2];
`ifdef LCD_RESPONDER_INIT_CHECK_EN
                        init_done <= 1'b1;
`endif
                    end
                    8'b00001???: {d, c, b} <= LCDbusIn[2:0];
                    8'b000001??: id <= LCDbusIn[1];
                    8'b0000001?: ac <= 7'h00;
                    8'b00000001: begin
                        ac <= 7'h00;
                        id <= 1'b1;
                    end
                    default: ;
                endcase
            end else if ((wr_ok & LCDrsSelect) | rd_ok) begin
                ac <= ac_step;
            end
        end
    end

    // DDRAM carries no reset; contents are only defined after the first clear.
    always_ff @(posedge clk) begin
        if (fill_on)
            ddram[fill_addr] <= 8'h20;
        else if (wr_ok & LCDrsSelect)
            ddram[ac] <= LCDbusIn;
    end

    always_comb begin
        LCDbusOe  = LCDonIn & LCDenableOut & LCDreadWriteSel;
        LCDbusOut = 8'h00;
        if (LCDbusOe)
            LCDbusOut = LCDrsSelect ? ddram[ac] : {bf, ac};
    end

    assign dbgData     = (dbgAddr <= LAST_ADDR) ? ddram[dbgAddr] : 8'h00;
    assign busyFlag    = bf;
    assign displayOn   = d;
    assign protocolErr = err;

endmodule

// File: tb/tb_lcd_responder.sv
// tb/tb_lcd_responder.sv - randomized self-checking bench for lcd_responder.
module tb_lcd_responder;

    localparam int BUSY       = 2000;
    localparam int CLEAR      = 50;
    localparam int CLEAR_BUSY = 80;
    localparam int LIMIT      = 5000;

    logic       clk = 1'b0;
    logic       rst_n, e, rs, rw;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_oe, busy_flag, display_on, prot_err;
    logic [6:0] dbg_addr;
    logic [7:0] dbg_data;

    lcd_responder #(.BUSY_CYCLES(BUSY), .CLEAR_CYCLES(CLEAR)) dut (
        .clk(clk), .LCDonIn(rst_n), .LCDenableOut(e), .LCDrsSelect(rs),
        .LCDreadWriteSel(rw), .LCDbusIn(bus_in), .LCDbusOut(bus_out),
        .LCDbusOe(bus_oe), .busyFlag(busy_flag), .displayOn(display_on),
        .protocolErr(prot_err), .dbgAddr(dbg_addr), .dbgData(dbg_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: the display as a plain array plus a cursor index.
    logic [7:0] m_ram [80];
    int         m_ac;
    bit         m_id, m_d, m_err, m_init;

    function automatic int step(input int a, input bit inc);
        return inc ? (a + 1) % 80 : (a + 79) % 80;
    endfunction

    function automatic void model_reset();
        m_ac = 0; m_id = 1; m_d = 0; m_err = 0; m_init = 0;
    endfunction

    function automatic int model_write(input bit rsv, input logic [7:0] v, input bit busy);
        int a;
        if (busy) begin
            m_err = 1;
            return 0;
        end
`ifdef LCD_RESPONDER_INIT_CHECK_EN
        if (!m_init && !(rsv == 0 && v >= 8'h20 && v < 8'h40)) begin
            m_err = 1;
            return 0;
        end
`endif
        if (rsv) begin
            m_ram[m_ac] = v;
            m_ac = step(m_ac, m_id);
            return BUSY;
        end
        if (v >= 8'h80) begin
            a = int'(v) - 128;
            m_ac = (a > 79) ? 0 : a;
        end else if (v >= 8'h40) begin
        end else if (v >= 8'h20) begin
            m_init = 1;
        end else if (v >= 8'h10) begin
        end else if (v >= 8'h08) begin
            m_d = v[2];
        end else if (v >= 8'h04) begin
            m_id = v[1];
        end else if (v >= 8'h02) begin
            m_ac = 0;
        end else if (v == 8'h01) begin
            for (int i = 0; i < 80; i++) m_ram[i] = 8'h20;
            m_ac = 0;
            m_id = 1;
            return CLEAR_BUSY;
        end
        return BUSY;
    endfunction

    task automatic do_write(input bit rsv, input logic [7:0] v);
        @(negedge clk); rs = rsv; rw = 0; bus_in = v; e = 1;
        @(negedge clk); e = 0;
        @(negedge clk);
    endtask

    task automatic do_read(input bit rsv, output logic [7:0] v, output logic oe);
        @(negedge clk); rs = rsv; rw = 1; e = 1;
        @(negedge clk); v = bus_out; oe = bus_oe; e = 0;
        @(negedge clk); rw = 0;
    endtask

    task automatic measure_busy(output int n);
        n = 0;
        while (busy_flag === 1'b1 && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n;
        measure_busy(n);
        if (n >= LIMIT) check("busy_timeout", n, 0);
    endtask

    task automatic wr(input bit rsv, input logic [7:0] v);
        int len;
        do_write(rsv, v);
        len = model_write(rsv, v, 0);
        wait_idle();
    endtask

    task automatic check_status(input string tag);
        logic [7:0] v;
        logic       oe;
        do_read(0, v, oe);
        check({tag, "_status"}, v, {1'b0, 7'(m_ac)});
        check({tag, "_disp"}, display_on, m_d);
        check({tag, "_err"}, prot_err, m_err);
    endtask

    task automatic hold_reset();
        @(negedge clk);
        rst_n = 0; e = 0; rs = 0; rw = 0; bus_in = 0; dbg_addr = 0;
        model_reset();
    endtask

    initial begin
        int         len, n;
        logic [7:0] v, w;
        logic       oe;

        hold_reset();
        e = 1; rw = 1;
        repeat (3) @(negedge clk);
        check("rst_oe", bus_oe, 0);
        check("rst_out", bus_out, 8'h00);
        check("rst_busy", busy_flag, 0);
        check("rst_err", prot_err, 0);
        check("rst_disp", display_on, 0);
        e = 0; rw = 0;
        @(negedge clk); rst_n = 1;

        // Display-on before any function set.
        do_write(0, 8'h0C);
        len = model_write(0, 8'h0C, 0);
        check("pre_init_disp", display_on, m_d);
        check("pre_init_err", prot_err, m_err);
        check("pre_init_busy", busy_flag, len > 0);
        rst_n = 0;
        #1;
        check("reset_aborts_busy", busy_flag, 0);
        hold_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;

        do_write(0, 8'h38);
        len = model_write(0, 8'h38, 0);
        fork
            measure_busy(n);
            begin
                repeat (100) @(negedge clk);
                do_read(0, v, oe);
            end
        join
        check("fset_busy_len", n, BUSY);
        check("busy_status", v, 8'h80);
        check("busy_status_oe", oe, 1);
        check("fset_err", prot_err, 0);

        do_write(0, 8'h01);
        len = model_write(0, 8'h01, 0);
        measure_busy(n);
        check("clear_busy_len", n, len);
        for (int a = 0; a < 80; a++) begin
            dbg_addr = 7'(a);
            #1;
            check("clear_fill", dbg_data, m_ram[a]);
        end
        check_status("after_clear");

        wr(0, 8'h06); wr(0, 8'hCF); wr(1, 8'h41);
        dbg_addr = 7'h4F; #1;
        check("wrap_up_data", dbg_data, 8'h41);
        check_status("wrap_up");

        wr(0, 8'h04); wr(0, 8'h80); wr(1, 8'h42);
        dbg_addr = 7'h00; #1;
        check("wrap_dn_data", dbg_data, 8'h42);
        check_status("wrap_dn");

        do_write(1, 8'h55);
        len = model_write(1, 8'h55, 0);
        do_write(1, 8'h99);
        len = model_write(1, 8'h99, 1);
        do_read(1, v, oe);
        m_err = 1;
        wait_idle();
        dbg_addr = 7'h4E; #1;
        check("busy_write_ram", dbg_data, m_ram[8'h4E]);
        check_status("busy_write");

        wr(0, 8'hD5);
        check_status("addr_clamp");

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: wr(1, 8'($urandom_range(0, 255)));
                4: wr(0, 8'h80 | 8'($urandom_range(0, 127)));
                5: wr(0, 8'h04 | 8'($urandom_range(0, 3)));
                6: wr(0, 8'h08 | 8'($urandom_range(0, 7)));
                7, 8: begin
                    w = m_ram[m_ac];
                    do_read(1, v, oe);
                    check("rand_read", v, w);
                    m_ac = step(m_ac, m_id);
                end
                default: begin
                    case ($urandom_range(0, 3))
                        0: v = 8'h02;
                        1: v = 8'h10 | 8'($urandom_range(0, 15));
                        2: v = 8'h40 | 8'($urandom_range(0, 63));
                        default: v = 8'h20 | 8'($urandom_range(0, 31));
                    endcase
                    wr(0, v);
                end
            endcase
            check_status("rand");
        end

        // E raised and never released produces no strobe.
        @(negedge clk); rs = 1; rw = 0; bus_in = 8'hAA; e = 1;
        repeat (20) @(negedge clk);
        check("held_e_busy", busy_flag, 0);
        check("held_e_err", prot_err, m_err);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
